// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Contents:
//   rx_state_t           receiver FSM state encoding
//   ADDR_DATA/STATUS     ioaddr decode values
//   STAT_*               bit positions inside the status byte
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  localparam int STAT_RDA  = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_FRM  = 3;
  localparam int STAT_PAR  = 4;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous FIFO holding received characters
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_data this cycle (ignored when full unless popping)
//   push_data    WIDTH-bit word to store
//   pop          remove the head word this cycle (ignored when empty)
//   full, empty  occupancy flags
//   head         oldest word, forced to zero while empty
module rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot at the same edge, so a push into a full FIFO
  // still lands when it is paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/receive_param.sv
// rtl/receive_param.sv - parameterised UART receiver with RX FIFO and status
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   brg_rx_en       one-clk oversample enable from the baud generator
//   rxd             asynchronous serial input, idle high
//   iocs, iorw      bus chip select, 1 = read
//   ioaddr          00 = data (FIFO head), 01 = status, others read 0
//   rx_buf          read data, combinational from ioaddr
//   rda             FIFO not empty
module receive_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brg_rx_en,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] rx_buf,
  output logic       rda
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  logic                 rxd_meta;
  logic                 rxd_s;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 ovr_q;
  logic                 frm_q;
  logic                 par_q;

  logic                 stop_done;
  logic                 frame_frm;
  logic [7:0]           frame_data;
  logic                 exp_par;
  logic                 data_rd;
  logic                 status_rd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;
  logic [7:0]           status;

  // Two-flop synchronizer; reset to the idle level so no false start
  // is seen right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign exp_par    = (^shift_q) ^ ODD_BIT;
  assign stop_done  = (state == STOP) && brg_rx_en && (tick_cnt == TICK_LAST);
  assign frame_frm  = ~rxd_s;
  assign frame_data = 8'(shift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state     <= START;
            tick_cnt  <= '0;
            par_err_q <= 1'b0;
          end
        end
        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (brg_rx_en) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxd_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        // Counting from mid start bit puts each sample at mid bit.
        DATA: begin
          if (brg_rx_en) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shift_q  <= {rxd_s, shift_q[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) begin
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        PARITY: begin
          if (brg_rx_en) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              par_err_q <= (rxd_s != exp_par);
              state     <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        // The push itself is decoded from stop_done so the word lands in
        // the FIFO on this very edge.
        STOP: begin
          if (brg_rx_en) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign data_rd   = iocs && iorw && (ioaddr == ADDR_DATA);
  assign status_rd = iocs && iorw && (ioaddr == ADDR_STATUS);

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stop_done),
    .push_data (frame_data),
    .pop       (data_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Sticky error bits: a status read clears them, but a set arriving on
  // the same edge survives. A pop on a full FIFO always succeeds, so the
  // paired push is never an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      ovr_q <= (stop_done && fifo_full && !data_rd) || (ovr_q && !status_rd);
      frm_q <= (stop_done && frame_frm) || (frm_q && !status_rd);
      par_q <= (stop_done && par_err_q) || (par_q && !status_rd);
    end
  end

  assign rda = ~fifo_empty;

  always_comb begin
    status            = '0;
    status[STAT_RDA]  = ~fifo_empty;
    status[STAT_FULL] = fifo_full;
    status[STAT_OVR]  = ovr_q;
    status[STAT_FRM]  = frm_q;
    status[STAT_PAR]  = par_q;
  end

  always_comb begin
    rx_buf = '0;
    case (ioaddr)
      ADDR_DATA:   rx_buf = fifo_head;
      ADDR_STATUS: rx_buf = status;
      default:     rx_buf = '0;
    endcase
  end

endmodule

// File: tb/tb_receive_param.sv
// tb/tb_receive_param.sv - scoreboard bench for receive_param (8 data bits, even parity, depth 4)
module tb_receive_param;

  localparam int OS      = 16;
  localparam int DEPTH   = 4;
  localparam int BRG_DIV = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       brg_rx_en = 1'b0;
  logic       rxd       = 1'b1;
  logic       iocs      = 1'b0;
  logic       iorw      = 1'b0;
  logic [1:0] ioaddr    = 2'b00;
  logic [7:0] rx_buf;
  logic       rda;

  receive_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .brg_rx_en (brg_rx_en),
    .rxd       (rxd),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .rx_buf    (rx_buf),
    .rda       (rda)
  );

  always #5 clk = ~clk;

  int brg_cnt = 0;
  always @(negedge clk) begin
    brg_rx_en = (brg_cnt == 0);
    brg_cnt   = (brg_cnt == BRG_DIV - 1) ? 0 : brg_cnt + 1;
  end

  // Reference model: the characters the receiver should be holding, in
  // arrival order, plus the sticky error flags.
  logic [7:0] exp_q[$];
  bit         m_ovr = 0;
  bit         m_frm = 0;
  bit         m_par = 0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (exp_q.size() != 0);
    s[1] = (exp_q.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_frm;
    s[4] = m_par;
    return s;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ovr = 0;
    m_frm = 0;
    m_par = 0;
  endfunction

  // Monitor: every bus read is compared against the model.
  always @(negedge clk) begin
    logic [7:0] head;
    if (rst_n && iocs && iorw) begin
      if (ioaddr == 2'b00) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          check("data", rx_buf, head);
        end else begin
          check("data_empty", rx_buf, 8'h00);
        end
      end else if (ioaddr == 2'b01) begin
        check("status", rx_buf, model_status());
        m_ovr = 0;
        m_frm = 0;
        m_par = 0;
      end else begin
        check("reserved", rx_buf, 8'h00);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!brg_rx_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic bus_access(input logic [1:0] addr, input logic rd);
    @(posedge clk);
    #1;
    iocs   = 1'b1;
    iorw   = rd;
    ioaddr = addr;
    @(posedge clk);
    #1;
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
  endtask

  // One frame: start, 8 data bits LSB first, even parity, stop, idle gap.
  // A bad stop bit is held low only for part of the bit so the receiver's
  // follow-on false start is rejected well before the next frame.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop);
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      wait_ticks(OS);
    end
    rxd = (^data) ^ bad_par;
    wait_ticks(OS);
    if (bad_stop) begin
      rxd = 1'b0;
      wait_ticks(12);
      rxd = 1'b1;
      wait_ticks(4);
    end else begin
      rxd = 1'b1;
      wait_ticks(OS);
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else m_ovr = 1;
    if (bad_stop) m_frm = 1;
    if (bad_par)  m_par = 1;
    wait_ticks(OS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         r;

    // Reset state
    rst_n  = 1'b0;
    ioaddr = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    check("reset_status", rx_buf, 8'h00);
    check("reset_rda", {7'b0, rda}, 8'h00);
    ioaddr = 2'b00;
    #1;
    check("reset_data", rx_buf, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    wait_ticks(4);

    // Clean frame 0xA5
    send_frame(8'hA5, 0, 0);
    check("rda_after_frame", {7'b0, rda}, 8'h01);
    bus_access(2'b01, 1'b1);
    bus_access(2'b00, 1'b1);
    check("rda_after_pop", {7'b0, rda}, 8'h00);
    bus_access(2'b01, 1'b1);

    // 0x07 with parity bit 0 (even parity needs 1)
    send_frame(8'h07, 1, 0);
    bus_access(2'b00, 1'b1);
    bus_access(2'b01, 1'b1);
    bus_access(2'b01, 1'b1);

    // 0x3C with stop bit low
    send_frame(8'h3C, 0, 1);
    bus_access(2'b01, 1'b1);
    bus_access(2'b00, 1'b1);

    // Five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0);
    bus_access(2'b01, 1'b1);
    for (int i = 0; i < 5; i++) bus_access(2'b00, 1'b1);
    bus_access(2'b01, 1'b1);

    // Short low glitch is not a start bit
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_rda", {7'b0, rda}, 8'h00);
    bus_access(2'b01, 1'b1);

    // Reset after three data bits of 0xF0 (bits 0..2 are 0)
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b0;
      wait_ticks(OS);
    end
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(2 * OS);
    bus_access(2'b01, 1'b1);
    send_frame(8'h55, 0, 0);
    bus_access(2'b00, 1'b1);
    bus_access(2'b01, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      bit bp;
      bit bs;
      d  = 8'($urandom);
      r  = $urandom_range(0, 5);
      bp = (r == 0);
      bs = (r == 1);
      if (exp_q.size() == DEPTH) begin
        bp = 0;
        bs = 0;
      end
      send_frame(d, bp, bs);
      if ($urandom_range(0, 4) == 0) bus_access(2'b00, 1'b0);
      if ($urandom_range(0, 5) == 0) bus_access(2'($urandom_range(2, 3)), 1'b1);
      if ($urandom_range(0, 2) == 0) bus_access(2'b01, 1'b1);
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) bus_access(2'b00, 1'b1);
    end

    // Drain
    bus_access(2'b01, 1'b1);
    for (int i = 0; i <= DEPTH; i++) bus_access(2'b00, 1'b1);
    bus_access(2'b01, 1'b1);
    check("final_rda", {7'b0, rda}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
